// File: rtl/ibex_mem_arbiter_if.sv
// ibex_mem_arbiter_if
// Groups the instruction port, the data port and the SRAM port of the
// Ibex memory arbiter into one bundle.
//   slave  : the arbiter's view. It receives requests, drives grants and
//            responses, and drives the SRAM request side.
//   master : the surroundings' view (core + SRAM), with every direction flipped.
// Clock and reset are plain ports on the arbiter and are not part of this bundle.
interface ibex_mem_arbiter_if;
    // instruction port
    logic        instr_req_i;
    logic [31:0] instr_addr_i;
    logic        instr_gnt_o;
    logic        instr_rvalid_o;
    logic [31:0] instr_rdata_o;
    logic        instr_err_o;
    // data port
    logic        data_req_i;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i;
    logic [31:0] data_wdata_i;
    logic        data_gnt_o;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        data_err_o;
    // SRAM port
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    modport slave (
        input  instr_req_i, instr_addr_i,
        output instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
        input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
        output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        input  mem_rvalid_i, mem_rdata_i
    );

    modport master (
        output instr_req_i, instr_addr_i,
        input  instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
        output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
        input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        output mem_rvalid_i, mem_rdata_i
    );
endinterface

// File: rtl/ibex_mem_arbiter.sv
// ibex_mem_arbiter
// Shares a single-port SRAM with 1-cycle read latency between the Ibex
// instruction and data interfaces.
// - The grant is combinational. The instruction port wins ties unless the
//   data port has been denied StarveLimit cycles in a row.
// - A granted address outside [MemStart, MemStart+MemSize) is not sent to
//   the SRAM. It gets an error response in the next cycle.
// - The response pipeline is one deep. It records who was granted and
//   routes the next cycle's SRAM response back to that port.
// Ports:
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset. While it is low, every output is 0.
//   bus    : instruction, data and SRAM signals (ibex_mem_arbiter_if.slave)
module ibex_mem_arbiter #(
    parameter int unsigned MemSize     = 8192,
    parameter logic [31:0] MemStart    = 32'h0000_0000,
    parameter int unsigned StarveLimit = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    ibex_mem_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_INSTR = 2'd1,
        OWN_DATA  = 2'd2
    } owner_e;

    localparam logic [31:0] AddrMask = ~(32'(MemSize) - 32'd1);
    localparam logic [3:0]  StarveMax = 4'(StarveLimit);

    logic [3:0] starve_cnt, starve_cnt_nxt;
    owner_e     resp_owner, resp_owner_nxt;
    logic       resp_err, resp_err_nxt;

    logic instr_in_range, data_in_range;
    logic instr_win, data_win, win_in_range;
    logic starved;

    assign instr_in_range = (bus.instr_addr_i & AddrMask) == MemStart;
    assign data_in_range  = (bus.data_addr_i  & AddrMask) == MemStart;
    assign starved        = (starve_cnt == StarveMax);

    // Arbitration. Gating with rst_ni keeps the grants and the SRAM request
    // at 0 during reset, even though they are combinational.
    // NOTE: every signal assigned in an always_comb gets a default at the top
    // of the block, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        instr_win = 1'b0;
        data_win  = 1'b0;
        if (rst_ni) begin
            if (bus.instr_req_i && bus.data_req_i) begin
                data_win  = starved;
                instr_win = !starved;
            end else begin
                instr_win = bus.instr_req_i;
                data_win  = bus.data_req_i;
            end
        end
    end

    assign win_in_range = (instr_win && instr_in_range) || (data_win && data_in_range);

    assign bus.instr_gnt_o = instr_win;
    assign bus.data_gnt_o  = data_win;

    // The SRAM request side stays all-zero unless an in-range winner is
    // forwarded. An instruction fetch never writes.
    always_comb begin
        bus.mem_req_o   = 1'b0;
        bus.mem_we_o    = 1'b0;
        bus.mem_be_o    = 4'b0000;
        bus.mem_addr_o  = 32'h0;
        bus.mem_wdata_o = 32'h0;
        if (win_in_range) begin
            bus.mem_req_o = 1'b1;
            if (data_win) begin
                bus.mem_we_o    = bus.data_we_i;
                bus.mem_be_o    = bus.data_be_i;
                bus.mem_addr_o  = bus.data_addr_i;
                bus.mem_wdata_o = bus.data_wdata_i;
            end else begin
                bus.mem_addr_o  = bus.instr_addr_i;
            end
        end
    end

    // The starvation counter counts consecutive cycles in which data asks
    // and is denied. It saturates at the limit and clears otherwise.
    always_comb begin
        starve_cnt_nxt = 4'd0;
        if (bus.data_req_i && !data_win) begin
            starve_cnt_nxt = starved ? starve_cnt : starve_cnt + 4'd1;
        end
    end

    always_comb begin
        resp_owner_nxt = OWN_NONE;
        if (data_win) begin
            resp_owner_nxt = OWN_DATA;
        end else if (instr_win) begin
            resp_owner_nxt = OWN_INSTR;
        end
        resp_err_nxt = (instr_win && !instr_in_range) || (data_win && !data_in_range);
    end

    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples values from before the edge, whatever order the blocks run in.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            starve_cnt <= 4'd0;
            resp_owner <= OWN_NONE;
            resp_err   <= 1'b0;
        end else begin
            starve_cnt <= starve_cnt_nxt;
            resp_owner <= resp_owner_nxt;
            resp_err   <= resp_err_nxt;
        end
    end

    // Response routing. An error response does not wait for the SRAM, and an
    // SRAM response that arrives with no owner, or with an error, is dropped.
    // rdata is 0 when there is no owner, so idle cycles read all-zero.
    logic        resp_active;
    logic        resp_valid;
    logic [31:0] resp_rdata;

    assign resp_active = rst_ni && (resp_owner != OWN_NONE);
    assign resp_valid  = resp_active && (resp_err || bus.mem_rvalid_i);
    assign resp_rdata  = (resp_active && !resp_err) ? bus.mem_rdata_i : 32'h0;

    assign bus.instr_rvalid_o = resp_valid && (resp_owner == OWN_INSTR);
    assign bus.instr_err_o    = resp_active && resp_err && (resp_owner == OWN_INSTR);
    assign bus.instr_rdata_o  = resp_rdata;
    assign bus.data_rvalid_o  = resp_valid && (resp_owner == OWN_DATA);
    assign bus.data_err_o     = resp_active && resp_err && (resp_owner == OWN_DATA);
    assign bus.data_rdata_o   = resp_rdata;

endmodule

// File: tb/tb_ibex_mem_arbiter.sv
// tb_ibex_mem_arbiter
// Directed test of ibex_mem_arbiter (MemSize 8192, MemStart 0, StarveLimit 4)
// against a small 1-cycle-latency SRAM model.
// Inputs change 1 time unit after the rising edge. Outputs are sampled on
// the falling edge. Each table row holds the stimulus for one cycle and the
// outputs expected in that cycle. Response fields refer to the row before.
module tb_ibex_mem_arbiter;

    logic clk_i = 1'b0;
    logic rst_ni;
    int   checks = 0;
    int   errors = 0;

    always #5 clk_i = ~clk_i;

    ibex_mem_arbiter_if bus ();

    ibex_mem_arbiter #(
        .MemSize     (8192),
        .MemStart    (32'h0000_0000),
        .StarveLimit (4)
    ) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    // SRAM model: 2048 words with 1-cycle read latency. It also answers
    // writes with rvalid. It ignores reset, so a response in flight across
    // a reset still reaches the arbiter.
    logic [31:0] ram [0:2047];
    logic        sram_rvalid = 1'b0;
    logic [31:0] sram_rdata  = 32'h0;

    always @(posedge clk_i) begin
        sram_rvalid <= bus.mem_req_o;
        if (bus.mem_req_o) begin
            sram_rdata <= ram[bus.mem_addr_o[12:2]];
            if (bus.mem_we_o) begin
                for (int b = 0; b < 4; b++) begin
                    if (bus.mem_be_o[b]) ram[bus.mem_addr_o[12:2]][8*b +: 8] <= bus.mem_wdata_o[8*b +: 8];
                end
            end
        end
    end

    assign bus.mem_rvalid_i = sram_rvalid;
    assign bus.mem_rdata_i  = sram_rdata;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    typedef struct {
        logic        ireq;
        logic [31:0] iaddr;
        logic        dreq;
        logic        dwe;
        logic [3:0]  dbe;
        logic [31:0] daddr;
        logic [31:0] dwdata;
        logic        e_ignt;
        logic        e_dgnt;
        logic        e_mreq;
        logic        e_mwe;
        logic [31:0] e_maddr;
        logic        e_irv;
        logic        e_drv;
        logic        e_err;
        logic        chk_rdata;
        logic [31:0] e_rdata;
    } vec_t;

    function automatic vec_t mk(
        input logic ireq, input logic [31:0] iaddr,
        input logic dreq, input logic dwe, input logic [3:0] dbe,
        input logic [31:0] daddr, input logic [31:0] dwdata,
        input logic e_ignt, input logic e_dgnt, input logic e_mreq,
        input logic e_mwe, input logic [31:0] e_maddr,
        input logic e_irv, input logic e_drv, input logic e_err,
        input logic chk_rdata, input logic [31:0] e_rdata);
        vec_t v;
        v.ireq = ireq;   v.iaddr = iaddr;
        v.dreq = dreq;   v.dwe = dwe;     v.dbe = dbe;
        v.daddr = daddr; v.dwdata = dwdata;
        v.e_ignt = e_ignt; v.e_dgnt = e_dgnt; v.e_mreq = e_mreq;
        v.e_mwe = e_mwe;   v.e_maddr = e_maddr;
        v.e_irv = e_irv;   v.e_drv = e_drv;   v.e_err = e_err;
        v.chk_rdata = chk_rdata; v.e_rdata = e_rdata;
        return v;
    endfunction

    task automatic drive(input logic ireq, input logic [31:0] iaddr,
                         input logic dreq, input logic dwe, input logic [3:0] dbe,
                         input logic [31:0] daddr, input logic [31:0] dwdata);
        bus.instr_req_i  = ireq;
        bus.instr_addr_i = iaddr;
        bus.data_req_i   = dreq;
        bus.data_we_i    = dwe;
        bus.data_be_i    = dbe;
        bus.data_addr_i  = daddr;
        bus.data_wdata_i = dwdata;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " instr_gnt"},    32'(bus.instr_gnt_o),    32'h0);
        check({tag, " data_gnt"},     32'(bus.data_gnt_o),     32'h0);
        check({tag, " mem_req"},      32'(bus.mem_req_o),      32'h0);
        check({tag, " mem_we"},       32'(bus.mem_we_o),       32'h0);
        check({tag, " mem_be"},       32'(bus.mem_be_o),       32'h0);
        check({tag, " mem_addr"},     bus.mem_addr_o,          32'h0);
        check({tag, " mem_wdata"},    bus.mem_wdata_o,         32'h0);
        check({tag, " instr_rvalid"}, 32'(bus.instr_rvalid_o), 32'h0);
        check({tag, " instr_err"},    32'(bus.instr_err_o),    32'h0);
        check({tag, " instr_rdata"},  bus.instr_rdata_o,       32'h0);
        check({tag, " data_rvalid"},  32'(bus.data_rvalid_o),  32'h0);
        check({tag, " data_err"},     32'(bus.data_err_o),     32'h0);
        check({tag, " data_rdata"},   bus.data_rdata_o,        32'h0);
    endtask

    vec_t vecs [14];

    initial begin
        for (int i = 0; i < 2048; i++) ram[i] = 32'h0;
        ram[32'h80 >> 2] = 32'h0000_0013;
        ram[1]           = 32'h1111_1111;

        // Fields: ireq iaddr | dreq we be daddr wdata | ignt dgnt mreq mwe maddr | irv drv err chk rdata
        vecs[0]  = mk(0, 32'h0,         0, 0, 4'h0, 32'h0,    32'h0,        0, 0, 0, 0, 32'h0,   0, 0, 0, 0, 32'h0);
        vecs[1]  = mk(1, 32'h80,        0, 0, 4'h0, 32'h0,    32'h0,        1, 0, 1, 0, 32'h80,  0, 0, 0, 0, 32'h0);
        vecs[2]  = mk(0, 32'h0,         1, 1, 4'hF, 32'h100,  32'hDEADBEEF, 0, 1, 1, 1, 32'h100, 1, 0, 0, 1, 32'h13);
        vecs[3]  = mk(0, 32'h0,         1, 0, 4'hF, 32'h100,  32'h0,        0, 1, 1, 0, 32'h100, 0, 1, 0, 0, 32'h0);
        vecs[4]  = mk(0, 32'h0,         0, 0, 4'h0, 32'h0,    32'h0,        0, 0, 0, 0, 32'h0,   0, 1, 0, 1, 32'hDEADBEEF);
        vecs[5]  = mk(0, 32'h0,         1, 0, 4'hF, 32'h2000, 32'h0,        0, 1, 0, 0, 32'h0,   0, 0, 0, 0, 32'h0);
        vecs[6]  = mk(0, 32'h0,         0, 0, 4'h0, 32'h0,    32'h0,        0, 0, 0, 0, 32'h0,   0, 1, 1, 1, 32'h0);
        vecs[7]  = mk(1, 32'h80,        0, 0, 4'h0, 32'h0,    32'h0,        1, 0, 1, 0, 32'h80,  0, 0, 0, 0, 32'h0);
        vecs[8]  = mk(0, 32'h0,         1, 0, 4'hF, 32'h100,  32'h0,        0, 1, 1, 0, 32'h100, 1, 0, 0, 1, 32'h13);
        vecs[9]  = mk(1, 32'h4,         0, 0, 4'h0, 32'h0,    32'h0,        1, 0, 1, 0, 32'h4,   0, 1, 0, 1, 32'hDEADBEEF);
        vecs[10] = mk(0, 32'h0,         1, 0, 4'hF, 32'h80,   32'h0,        0, 1, 1, 0, 32'h80,  1, 0, 0, 1, 32'h11111111);
        vecs[11] = mk(0, 32'h0,         0, 0, 4'h0, 32'h0,    32'h0,        0, 0, 0, 0, 32'h0,   0, 1, 0, 1, 32'h13);
        vecs[12] = mk(1, 32'hFFFF0000,  0, 0, 4'h0, 32'h0,    32'h0,        1, 0, 0, 0, 32'h0,   0, 0, 0, 0, 32'h0);
        vecs[13] = mk(0, 32'h0,         0, 0, 4'h0, 32'h0,    32'h0,        0, 0, 0, 0, 32'h0,   1, 0, 1, 1, 32'h0);

        // Reset with both ports requesting: every output must read 0.
        rst_ni = 1'b0;
        drive(1, 32'h80, 1, 0, 4'hF, 32'h100, 32'h0);
        @(negedge clk_i);
        check_all_zero("in_reset");
        @(posedge clk_i); #1;
        drive(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
        rst_ni = 1'b1;
        @(negedge clk_i);
        check_all_zero("after_release");

        // Table-driven single, back-to-back, alternating and out-of-range accesses.
        for (int i = 0; i < 14; i++) begin
            @(posedge clk_i); #1;
            drive(vecs[i].ireq, vecs[i].iaddr, vecs[i].dreq, vecs[i].dwe,
                  vecs[i].dbe, vecs[i].daddr, vecs[i].dwdata);
            @(negedge clk_i);
            check($sformatf("v%0d instr_gnt", i),    32'(bus.instr_gnt_o),    32'(vecs[i].e_ignt));
            check($sformatf("v%0d data_gnt", i),     32'(bus.data_gnt_o),     32'(vecs[i].e_dgnt));
            check($sformatf("v%0d mem_req", i),      32'(bus.mem_req_o),      32'(vecs[i].e_mreq));
            check($sformatf("v%0d mem_we", i),       32'(bus.mem_we_o),       32'(vecs[i].e_mwe));
            check($sformatf("v%0d mem_addr", i),     bus.mem_addr_o,          vecs[i].e_maddr);
            check($sformatf("v%0d instr_rvalid", i), 32'(bus.instr_rvalid_o), 32'(vecs[i].e_irv));
            check($sformatf("v%0d data_rvalid", i),  32'(bus.data_rvalid_o),  32'(vecs[i].e_drv));
            check($sformatf("v%0d instr_err", i),    32'(bus.instr_err_o),    32'(vecs[i].e_irv & vecs[i].e_err));
            check($sformatf("v%0d data_err", i),     32'(bus.data_err_o),     32'(vecs[i].e_drv & vecs[i].e_err));
            if (vecs[i].chk_rdata) begin
                check($sformatf("v%0d instr_rdata", i), bus.instr_rdata_o, vecs[i].e_rdata);
                check($sformatf("v%0d data_rdata", i),  bus.data_rdata_o,  vecs[i].e_rdata);
            end
        end

        // Starvation: both ports request every cycle. The expected pattern is
        // 4 instruction grants, then 1 data grant, repeating.
        begin
            logic prev_i = 1'b0;
            logic prev_d = 1'b0;
            for (int c = 0; c < 12; c++) begin
                logic exp_d;
                exp_d = (c % 5 == 4);
                @(posedge clk_i); #1;
                drive(1, 32'h80, 1, 0, 4'hF, 32'h100, 32'h0);
                @(negedge clk_i);
                check($sformatf("starve c%0d instr_gnt", c),    32'(bus.instr_gnt_o),    32'(!exp_d));
                check($sformatf("starve c%0d data_gnt", c),     32'(bus.data_gnt_o),     32'(exp_d));
                check($sformatf("starve c%0d instr_rvalid", c), 32'(bus.instr_rvalid_o), 32'(prev_i));
                check($sformatf("starve c%0d data_rvalid", c),  32'(bus.data_rvalid_o),  32'(prev_d));
                if (prev_i || prev_d) begin
                    check($sformatf("starve c%0d rdata", c), bus.instr_rdata_o,
                          prev_i ? 32'h0000_0013 : 32'hDEADBEEF);
                end
                prev_i = !exp_d;
                prev_d = exp_d;
            end
        end

        // Reset in the cycle after an instruction grant: the pending response
        // is dropped, even though the SRAM answers.
        @(posedge clk_i); #1;
        drive(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
        @(posedge clk_i); #1;
        drive(1, 32'h80, 0, 0, 4'h0, 32'h0, 32'h0);
        @(negedge clk_i);
        check("rst_seq instr_gnt", 32'(bus.instr_gnt_o), 32'h1);
        @(posedge clk_i); #1;
        rst_ni = 1'b0;
        drive(1, 32'h80, 1, 0, 4'hF, 32'h100, 32'h0);
        @(negedge clk_i);
        check("rst_seq sram_answered", 32'(bus.mem_rvalid_i), 32'h1);
        check_all_zero("rst_mid");
        @(posedge clk_i); #1;
        @(negedge clk_i);
        check_all_zero("rst_hold");
        @(posedge clk_i); #1;
        drive(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
        rst_ni = 1'b1;
        @(negedge clk_i);
        check_all_zero("rst_release");
        @(posedge clk_i); #1;
        @(negedge clk_i);
        check_all_zero("rst_release_next");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
